// File: rtl/cnn_core_pkg.sv
// Shared widths and helpers for the CNN core MAC datapath.
package cnn_core_pkg;
  localparam int MUL_A_W   = 12;
  localparam int MUL_B_W   = 8;
  localparam int MUL_P_W   = 20;
  localparam int DEF_ACC_W = 32;

  // Sign-extend a multiplier product; callers cast down to their accumulator width.
  function automatic logic [63:0] sext_prod(input logic [MUL_P_W-1:0] p);
    return {{(64-MUL_P_W){p[MUL_P_W-1]}}, p};
  endfunction
endpackage

// File: rtl/cnn_core_mul_12s_8s_20_1_0.sv
// Combinational signed 12x8 -> 20 multiplier shared by the MAC arbiter.
module cnn_core_mul_12s_8s_20_1_0 #(
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 20
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);
  logic signed [dout_WIDTH-1:0] w_a, w_b;

  assign w_a  = dout_WIDTH'($signed(din0));
  assign w_b  = dout_WIDTH'($signed(din1));
  assign dout = w_a * w_b;
endmodule

// File: rtl/cnn_core_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wrap.
module cnn_core_rr_arb #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  input  logic          i_acc_clr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_id
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        w_found    = 1'b1;
        o_grant_id = w_idx;
      end
    end
    // A clear pulse blocks the grant but the id stays meaningful.
    if (w_found && !i_acc_clr) o_grant[o_grant_id] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= '0;
    else if (i_advance) r_ptr <= (o_grant_id == IW'(N-1)) ? '0 : o_grant_id + 1'b1;
  end
endmodule

// File: rtl/cnn_core_mac_arbiter.sv
// Time-shares one 12x8 multiplier across NUM_REQ streams, one accumulator per stream,
// emitting a tagged sum on each stream's last pair.
module cnn_core_mac_arbiter
  import cnn_core_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  ACC_W   = DEF_ACC_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       acc_clr,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*MUL_A_W-1:0] req_din0,
  input  logic [NUM_REQ*MUL_B_W-1:0] req_din1,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [ACC_W-1:0]           res_data,
  output logic                       idle
);
  logic                            w_stall, w_hs, w_fire;
  logic [NUM_REQ-1:0]              w_grant;
  logic [ID_W-1:0]                 w_gid;
  logic [MUL_P_W-1:0]              w_prod;
  logic [ACC_W-1:0]                w_sum;

  logic                            r_s1_valid, r_s1_last;
  logic [ID_W-1:0]                 r_s1_id;
  logic [MUL_A_W-1:0]              r_s1_a;
  logic [MUL_B_W-1:0]              r_s1_b;
  logic [NUM_REQ-1:0][ACC_W-1:0]   r_acc;
  logic                            r_res_valid;
  logic [ID_W-1:0]                 r_res_id;
  logic [ACC_W-1:0]                r_res_data;

  assign w_stall   = r_res_valid & ~res_ready;
  assign req_ready = w_grant & {NUM_REQ{~w_stall & ap_rst_n}};
  assign w_hs      = |req_ready;
  assign w_fire    = r_s1_valid & ~w_stall & ~acc_clr;

  cnn_core_rr_arb #(.N(NUM_REQ)) u_arb (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_req      (req_valid),
    .i_advance  (w_hs),
    .i_acc_clr  (acc_clr),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  cnn_core_mul_12s_8s_20_1_0 u_mul (
    .din0 (r_s1_a),
    .din1 (r_s1_b),
    .dout (w_prod)
  );

  // Wraps modulo 2^ACC_W by construction.
  assign w_sum = r_acc[r_s1_id] + ACC_W'(sext_prod(w_prod));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_id    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (acc_clr) begin
      r_s1_valid <= 1'b0;
    end else if (w_hs) begin
      r_s1_valid <= 1'b1;
      r_s1_last  <= req_last[w_gid];
      r_s1_id    <= w_gid;
      r_s1_a     <= req_din0[w_gid*MUL_A_W +: MUL_A_W];
      r_s1_b     <= req_din1[w_gid*MUL_B_W +: MUL_B_W];
    end else if (!w_stall) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)   r_acc <= '0;
    else if (acc_clr) r_acc <= '0;
    else if (w_fire)  r_acc[r_s1_id] <= r_s1_last ? '0 : w_sum;
  end

  // A new result may load in the same cycle the previous one is taken.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else if (w_fire && r_s1_last) begin
      r_res_valid <= 1'b1;
      r_res_id    <= r_s1_id;
      r_res_data  <= w_sum;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign idle      = ~r_s1_valid & ~r_res_valid;
endmodule

// File: tb/tb_cnn_core_mac_arbiter.sv
// Bench for cnn_core_mac_arbiter: directed scenarios plus random traffic against a reference model.
module tb_cnn_core_mac_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;

  logic            ap_clk = 1'b0, ap_rst_n = 1'b0, acc_clr = 1'b0, res_ready = 1'b0;
  logic [N-1:0]    req_valid = '0, req_last = '0;
  logic [N*12-1:0] req_din0 = '0;
  logic [N*8-1:0]  req_din1 = '0;
  logic [N-1:0]    req_ready;
  logic            res_valid, idle;
  logic [1:0]      res_id;
  logic [AW-1:0]   res_data;

  // Narrow-accumulator instance for the wrap scenario.
  logic            w_clr = 1'b0, w_rrdy = 1'b1;
  logic [N-1:0]    w_valid = '0, w_last = '0;
  logic [N*12-1:0] w_din0 = '0;
  logic [N*8-1:0]  w_din1 = '0;
  logic [N-1:0]    w_ready;
  logic            w_rvalid, w_idle;
  logic [1:0]      w_rid;
  logic [19:0]     w_rdata;

  cnn_core_mac_arbiter #(.NUM_REQ(N), .ACC_W(AW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .acc_clr(acc_clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_din0(req_din0), .req_din1(req_din1),
    .req_last(req_last), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .idle(idle));

  cnn_core_mac_arbiter #(.NUM_REQ(N), .ACC_W(20)) dut_w (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .acc_clr(w_clr),
    .req_valid(w_valid), .req_ready(w_ready), .req_din0(w_din0), .req_din1(w_din1),
    .req_last(w_last), .res_valid(w_rvalid), .res_ready(w_rrdy), .res_id(w_rid),
    .res_data(w_rdata), .idle(w_idle));

  always #5 ap_clk = ~ap_clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- reference model ----------------
  int            m_ptr = 0, m_s1id = 0, m_s1a = 0, m_s1b = 0, m_rid = 0;
  bit            m_s1v = 0, m_s1last = 0, m_rv = 0;
  logic [AW-1:0] m_acc [N];
  logic [AW-1:0] m_rdata = '0;
  int            mc_g;
  bit            mc_stall, mc_hs;
  logic [AW-1:0] mc_sum;
  logic [N-1:0]  mc_ready;

  initial foreach (m_acc[i]) m_acc[i] = '0;

  always_comb begin
    mc_g = -1;
    for (int k = 0; k < N; k++)
      if (mc_g < 0 && req_valid[(m_ptr + k) % N]) mc_g = (m_ptr + k) % N;
    mc_stall = m_rv && !res_ready;
    mc_hs    = (mc_g >= 0) && !mc_stall && !acc_clr && ap_rst_n;
    mc_ready = mc_hs ? N'(1) << mc_g : '0;
    mc_sum   = m_acc[m_s1id] + AW'(m_s1a * m_s1b);
  end

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_ptr <= 0; m_s1v <= 0; m_s1last <= 0; m_s1id <= 0; m_s1a <= 0; m_s1b <= 0;
      foreach (m_acc[i]) m_acc[i] <= '0;
      m_rv <= 0; m_rid <= 0; m_rdata <= '0;
    end else begin
      if (acc_clr) foreach (m_acc[i]) m_acc[i] <= '0;
      else if (m_s1v && !mc_stall) m_acc[m_s1id] <= m_s1last ? '0 : mc_sum;
      if (!acc_clr && m_s1v && !mc_stall && m_s1last) begin
        m_rv <= 1; m_rid <= m_s1id; m_rdata <= mc_sum;
      end else if (m_rv && res_ready) m_rv <= 0;
      if (acc_clr) m_s1v <= 0;
      else if (mc_hs) begin
        m_s1v    <= 1;
        m_s1id   <= mc_g;
        m_s1a    <= int'($signed(req_din0[12*mc_g +: 12]));
        m_s1b    <= int'($signed(req_din1[8*mc_g +: 8]));
        m_s1last <= req_last[mc_g];
      end else if (!mc_stall) m_s1v <= 0;
      if (mc_hs) m_ptr <= (mc_g + 1) % N;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, mc_ready);
      check("res_valid", res_valid, m_rv);
      check("res_id",    res_id,    m_rid);
      check("res_data",  res_data,  m_rdata);
      check("idle",      idle,      !m_s1v && !m_rv);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ap_clk); #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 0; req_valid = '0; req_last = '0; acc_clr = 0;
    tick(); tick();
    ap_rst_n = 1;
    tick();
  endtask

  task automatic send(input int ch, input int a, input int b, input bit last);
    bit hs = 0;
    int n = 0;
    req_valid[ch] = 1'b1;
    req_din0[12*ch +: 12] = 12'(a);
    req_din1[8*ch +: 8]   = 8'(b);
    req_last[ch] = last;
    while (!hs && n < 50) begin
      @(negedge ap_clk); hs = req_ready[ch]; n++;
      tick();
    end
    check("send_handshake", hs, 1);
    req_valid[ch] = 1'b0;
    req_last[ch]  = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    @(negedge ap_clk);
    while (!res_valid && n < 50) begin @(negedge ap_clk); n++; end
    check("res_seen", res_valid, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int order[$], rids[$], rdat[$], cnt[N];
    logic [N-1:0] rdy;

    do_reset();
    chk_en = 1;
    res_ready = 1;
    @(negedge ap_clk);
    check("rst_idle", idle, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    tick();

    // single channel window
    send(0, 100, 3, 0);
    send(0, -5, 7, 0);
    send(0, 2047, -128, 1);
    wait_res();
    check("t1_id", res_id, 0);
    check("t1_data", 64'($signed(res_data)), -261751);
    check("t1_model_pin", 64'($signed(m_rdata)), -261751);
    tick();
    send(0, 7, 1, 1);
    wait_res();
    check("t1_acc_zeroed", res_data, 7);
    tick();

    // round robin across all channels
    do_reset();
    res_ready = 1;
    req_valid = '1; req_din0 = {N{12'd1}}; req_din1 = {N{8'd1}}; req_last = '0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge ap_clk);
      rdy = req_ready;
      if (req_valid != '0) check("rr_one_grant", $countones(rdy), 1);
      if (res_valid) begin rids.push_back(int'(res_id)); rdat.push_back(int'(res_data)); end
      tick();
      for (int i = 0; i < N; i++) if (rdy[i]) begin
        order.push_back(i);
        cnt[i]++;
        if (cnt[i] == 1) req_last[i] = 1'b1;
        else begin req_valid[i] = 1'b0; req_last[i] = 1'b0; end
      end
    end
    check("rr_grant_count", order.size(), 8);
    for (int k = 0; k < order.size(); k++) check("rr_grant_order", order[k], k % N);
    check("rr_result_count", rids.size(), 4);
    for (int k = 0; k < rids.size(); k++) begin
      check("rr_result_id", rids[k], k);
      check("rr_result_data", rdat[k], 2);
    end

    // backpressure
    do_reset();
    res_ready = 0;
    send(1, 3, 3, 1);
    send(0, 5, 2, 1);
    req_valid[2] = 1; req_din0[24 +: 12] = 12'd4; req_din1[16 +: 8] = 8'd4; req_last[2] = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check("bp_ready_blocked", req_ready, 0);
      check("bp_hold_id", res_id, 1);
      check("bp_hold_data", res_data, 9);
      check("bp_busy", idle, 0);
      tick();
    end
    res_ready = 1;
    @(negedge ap_clk);
    check("bp_ready_resume", req_ready, 4'b0100);
    tick();
    req_valid[2] = 0; req_last[2] = 0;
    @(negedge ap_clk);
    check("bp_next_valid", res_valid, 1);
    check("bp_next_id", res_id, 0);
    check("bp_next_data", res_data, 10);
    tick();
    @(negedge ap_clk);
    check("bp_third_id", res_id, 2);
    check("bp_third_data", res_data, 16);
    tick();

    // acc_clr mid-window
    do_reset();
    res_ready = 1;
    send(2, 10, 10, 0);
    send(2, 10, 10, 0);
    tick();
    acc_clr = 1; tick(); acc_clr = 0;
    send(2, 1, 1, 1);
    wait_res();
    check("clr_id", res_id, 2);
    check("clr_data", res_data, 1);
    tick();

    // async reset with result pending and stage 1 full
    do_reset();
    res_ready = 0;
    send(3, 4, 4, 1);
    send(3, 2, 2, 0);
    req_valid[0] = 1; req_din0[0 +: 12] = 12'd9; req_din1[0 +: 8] = 8'd9;
    @(negedge ap_clk);
    check("ar_pending", res_valid, 1);
    check("ar_busy", idle, 0);
    #2 ap_rst_n = 0;
    #1;
    check("ar_res_valid_drop", res_valid, 0);
    check("ar_ready_drop", req_ready, 0);
    check("ar_idle", idle, 1);
    req_valid = '0;
    tick(); tick();
    ap_rst_n = 1; res_ready = 1;
    send(3, 1, 5, 1);
    wait_res();
    check("ar_fresh_id", res_id, 3);
    check("ar_fresh_data", res_data, 5);
    tick();

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom);
      req_din0  = {$urandom, $urandom};
      req_din1  = $urandom;
      req_last  = N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) req_din0[12*$urandom_range(0, N-1) +: 12] = 12'h800;
      res_ready = ($urandom_range(0, 3) != 0);
      acc_clr   = ($urandom_range(0, 39) == 0);
      tick();
    end
    req_valid = '0; acc_clr = 0; res_ready = 1;
    tick(); tick(); tick();
    chk_en = 0;

    // wrap on the 20-bit accumulator build
    w_din0[0 +: 12] = 12'h800;
    w_din1[0 +: 8]  = 8'h80;
    w_valid[0] = 1;
    for (int k = 0; k < 65; k++) begin
      w_last[0] = (k == 64);
      @(negedge ap_clk);
      check("wrap_ready", w_ready, 4'b0001);
      tick();
    end
    w_valid = '0; w_last = '0;
    begin
      int n = 0;
      @(negedge ap_clk);
      while (!w_rvalid && n < 20) begin @(negedge ap_clk); n++; end
    end
    check("wrap_seen", w_rvalid, 1);
    check("wrap_id", w_rid, 0);
    check("wrap_data", w_rdata, 20'd262144);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
